// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared requester indices and constants for the write-back port arbiter
package wb_arb_pkg;

    localparam int          N_REQ    = 4;
    localparam logic [1:0]  REQ_ALU  = 2'd0;
    localparam logic [1:0]  REQ_FPU  = 2'd1;
    localparam logic [1:0]  REQ_LOAD = 2'd2;
    localparam logic [1:0]  REQ_MDU  = 2'd3;
    localparam logic [4:0]  ZERO_REG = 5'd0;

    function automatic logic multi_hot(input logic [N_REQ-1:0] v);
        return (v & (v - 4'd1)) != '0;
    endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// rtl/wb_port_arbiter_if.sv - requester/write-port bundle between execute producers and the arbiter
interface wb_port_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    import wb_arb_pkg::*;

    logic [N_REQ-1:0]  req;
    logic [ADDR_W-1:0] req_addr0;
    logic [ADDR_W-1:0] req_addr1;
    logic [ADDR_W-1:0] req_addr2;
    logic [ADDR_W-1:0] req_addr3;
    logic [DATA_W-1:0] req_data0;
    logic [DATA_W-1:0] req_data1;
    logic [DATA_W-1:0] req_data2;
    logic [DATA_W-1:0] req_data3;
    logic              wb_hold;
    logic [N_REQ-1:0]  gnt;
    logic [1:0]        sel;
    logic              conflict;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output req, req_addr0, req_addr1, req_addr2, req_addr3,
               req_data0, req_data1, req_data2, req_data3, wb_hold,
        input  gnt, sel, conflict, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  req, req_addr0, req_addr1, req_addr2, req_addr3,
               req_data0, req_data1, req_data2, req_data3, wb_hold,
        output gnt, sel, conflict, wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/mux4to1by32.sv
// rtl/mux4to1by32.sv - 4:1 multiplexer, 32-bit
module mux4to1by32 (
    input  logic [1:0]  s,
    input  logic [31:0] d0,
    input  logic [31:0] d1,
    input  logic [31:0] d2,
    input  logic [31:0] d3,
    output logic [31:0] y
);

    always_comb begin
        case (s)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            default: y = d3;
        endcase
    end

endmodule

// File: rtl/mux4to1by5.sv
// rtl/mux4to1by5.sv - 4:1 multiplexer, 5-bit
module mux4to1by5 (
    input  logic [1:0] s,
    input  logic [4:0] d0,
    input  logic [4:0] d1,
    input  logic [4:0] d2,
    input  logic [4:0] d3,
    output logic [4:0] y
);

    always_comb begin
        case (s)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            default: y = d3;
        endcase
    end

endmodule

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational 4-way rotating-priority picker (one-hot grant + encoded index)
module rr_pick4
    import wb_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       ptr,
    input  logic             hold,
    output logic [N_REQ-1:0] gnt,
    output logic [1:0]       sel,
    output logic             valid
);

    logic [1:0] idx;

    always_comb begin
        gnt   = '0;
        sel   = 2'd0;
        valid = 1'b0;
        idx   = ptr;
        if (!hold) begin
            // Scan ptr, ptr+1, ... mod 4; the first set request wins.
            for (int k = 0; k < N_REQ; k++) begin
                idx = ptr + 2'(k);
                if (!valid && req[idx]) begin
                    gnt[idx] = 1'b1;
                    sel      = idx;
                    valid    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - round-robin arbiter for the shared register-file write port
// Define WBARB_FIXED_PRIO_EN for fixed priority ALU > FPU > LOAD > MDU.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    wb_port_arbiter_if.slave   bus
);

    logic [1:0]        ptr;
    logic [1:0]        last_sel;
    logic [1:0]        pick_sel;
    logic [N_REQ-1:0]  pick_gnt;
    logic              pick_valid;
    logic [ADDR_W-1:0] mux_addr;
    logic [DATA_W-1:0] mux_data;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;

    // Reset masks grants the same way hold does.
    rr_pick4 u_pick (
        .req   (bus.req),
        .ptr   (ptr),
        .hold  (bus.wb_hold | reset),
        .gnt   (pick_gnt),
        .sel   (pick_sel),
        .valid (pick_valid)
    );

    assign bus.gnt      = pick_gnt;
    assign bus.sel      = pick_valid ? pick_sel : last_sel;
    assign bus.conflict = multi_hot(bus.req) & ~bus.wb_hold & ~reset;

    mux4to1by5 u_addr_mux (
        .s  (bus.sel),
        .d0 (bus.req_addr0),
        .d1 (bus.req_addr1),
        .d2 (bus.req_addr2),
        .d3 (bus.req_addr3),
        .y  (mux_addr)
    );

    mux4to1by32 u_data_mux (
        .s  (bus.sel),
        .d0 (bus.req_data0),
        .d1 (bus.req_data1),
        .d2 (bus.req_data2),
        .d3 (bus.req_data3),
        .y  (mux_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            last_sel  <= 2'd0;
        end else begin
            wr_en_q <= 1'b0;
            if (pick_valid) begin
                // $zero writes are consumed (granted) but never reach the file.
                wr_en_q   <= (mux_addr != ADDR_W'(ZERO_REG));
                wr_addr_q <= mux_addr;
                wr_data_q <= mux_data;
                last_sel  <= pick_sel;
            end
        end
    end

`ifdef WBARB_FIXED_PRIO_EN
    assign ptr = REQ_ALU;
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= REQ_ALU;
        end else if (pick_valid) begin
            ptr <= pick_sel + 2'd1;
        end
    end
`endif

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - table-driven self-checking bench for wb_port_arbiter
module tb_wb_port_arbiter;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic        hold;
        logic [4:0]  a0;
        logic [3:0]  gnt;
        logic [1:0]  sel;
        logic        conf;
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    vec_t tbl[$];

    wb_port_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    wb_port_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset         = 1'b1;
        bus.req       = 4'b0000;
        bus.wb_hold   = 1'b0;
        bus.req_addr0 = 5'd3;
        bus.req_addr1 = 5'd7;
        bus.req_addr2 = 5'd12;
        bus.req_addr3 = 5'd20;
        bus.req_data0 = 32'hDEADBEEF;
        bus.req_data1 = 32'h3F800000;
        bus.req_data2 = 32'h22222222;
        bus.req_data3 = 32'h33333333;

        //                rst  req     hold a0     gnt     sel  conf wen  waddr  wdata
`ifdef WBARB_FIXED_PRIO_EN
        tbl.push_back('{1'b1, 4'b0000, 1'b0, 5'd3, 4'b0000, 2'd0, 1'b0, 1'b0, 5'd0,  32'h0});
        tbl.push_back('{1'b0, 4'b0101, 1'b0, 5'd3, 4'b0001, 2'd0, 1'b1, 1'b0, 5'd0,  32'h0});
        tbl.push_back('{1'b0, 4'b0101, 1'b0, 5'd3, 4'b0001, 2'd0, 1'b1, 1'b1, 5'd3,  32'hDEADBEEF});
        tbl.push_back('{1'b0, 4'b0101, 1'b0, 5'd3, 4'b0001, 2'd0, 1'b1, 1'b1, 5'd3,  32'hDEADBEEF});
        tbl.push_back('{1'b0, 4'b0100, 1'b0, 5'd3, 4'b0100, 2'd2, 1'b0, 1'b1, 5'd3,  32'hDEADBEEF});
        tbl.push_back('{1'b0, 4'b1111, 1'b0, 5'd3, 4'b0001, 2'd0, 1'b1, 1'b1, 5'd12, 32'h22222222});
`else
        tbl.push_back('{1'b1, 4'b0000, 1'b0, 5'd3, 4'b0000, 2'd0, 1'b0, 1'b0, 5'd0,  32'h0});
        tbl.push_back('{1'b0, 4'b0010, 1'b0, 5'd3, 4'b0010, 2'd1, 1'b0, 1'b0, 5'd0,  32'h0});
        tbl.push_back('{1'b0, 4'b0000, 1'b0, 5'd3, 4'b0000, 2'd1, 1'b0, 1'b1, 5'd7,  32'h3F800000});
        tbl.push_back('{1'b1, 4'b0000, 1'b0, 5'd3, 4'b0000, 2'd0, 1'b0, 1'b0, 5'd0,  32'h0});
        tbl.push_back('{1'b0, 4'b1111, 1'b0, 5'd3, 4'b0001, 2'd0, 1'b1, 1'b0, 5'd0,  32'h0});
        tbl.push_back('{1'b0, 4'b1111, 1'b0, 5'd3, 4'b0010, 2'd1, 1'b1, 1'b1, 5'd3,  32'hDEADBEEF});
        tbl.push_back('{1'b0, 4'b1111, 1'b0, 5'd3, 4'b0100, 2'd2, 1'b1, 1'b1, 5'd7,  32'h3F800000});
        tbl.push_back('{1'b0, 4'b1111, 1'b0, 5'd3, 4'b1000, 2'd3, 1'b1, 1'b1, 5'd12, 32'h22222222});
        tbl.push_back('{1'b0, 4'b0001, 1'b0, 5'd0, 4'b0001, 2'd0, 1'b0, 1'b1, 5'd20, 32'h33333333});
        tbl.push_back('{1'b0, 4'b0110, 1'b1, 5'd3, 4'b0000, 2'd0, 1'b0, 1'b0, 5'd0,  32'hDEADBEEF});
        tbl.push_back('{1'b0, 4'b0110, 1'b1, 5'd3, 4'b0000, 2'd0, 1'b0, 1'b0, 5'd0,  32'hDEADBEEF});
        tbl.push_back('{1'b0, 4'b0110, 1'b0, 5'd3, 4'b0010, 2'd1, 1'b1, 1'b0, 5'd0,  32'hDEADBEEF});
        tbl.push_back('{1'b0, 4'b0100, 1'b0, 5'd3, 4'b0100, 2'd2, 1'b0, 1'b1, 5'd7,  32'h3F800000});
        tbl.push_back('{1'b0, 4'b1010, 1'b0, 5'd3, 4'b1000, 2'd3, 1'b1, 1'b1, 5'd12, 32'h22222222});
        tbl.push_back('{1'b0, 4'b1010, 1'b0, 5'd3, 4'b0010, 2'd1, 1'b1, 1'b1, 5'd20, 32'h33333333});
`endif

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            reset         = tbl[i].rst;
            bus.req       = tbl[i].req;
            bus.wb_hold   = tbl[i].hold;
            bus.req_addr0 = tbl[i].a0;
            #1;
            check($sformatf("v%0d gnt", i),      32'(bus.gnt),      32'(tbl[i].gnt));
            check($sformatf("v%0d sel", i),      32'(bus.sel),      32'(tbl[i].sel));
            check($sformatf("v%0d conflict", i), 32'(bus.conflict), 32'(tbl[i].conf));
            check($sformatf("v%0d wr_en", i),    32'(bus.wr_en),    32'(tbl[i].wen));
            check($sformatf("v%0d wr_addr", i),  32'(bus.wr_addr),  32'(tbl[i].waddr));
            check($sformatf("v%0d wr_data", i),  bus.wr_data,       tbl[i].wdata);
        end

        // Mid-stream asynchronous reset with a registered write in flight.
        @(negedge clk);
        reset         = 1'b0;
        bus.wb_hold   = 1'b0;
        bus.req_addr0 = 5'd3;
        bus.req       = 4'b0100;
        #1;
        check("pre gnt", 32'(bus.gnt), 32'(4'b0100));
        @(negedge clk);
        bus.req = 4'b1010;
        #1;
        check("pre wr_en",   32'(bus.wr_en),   32'd1);
        check("pre wr_addr", 32'(bus.wr_addr), 32'd12);
`ifdef WBARB_FIXED_PRIO_EN
        check("pre gnt2", 32'(bus.gnt), 32'(4'b0010));
`else
        check("pre gnt2", 32'(bus.gnt), 32'(4'b1000));
`endif
        #1;
        reset = 1'b1;
        #1;
        check("rst wr_en",    32'(bus.wr_en),    32'd0);
        check("rst wr_addr",  32'(bus.wr_addr),  32'd0);
        check("rst wr_data",  bus.wr_data,       32'd0);
        check("rst gnt",      32'(bus.gnt),      32'd0);
        check("rst conflict", 32'(bus.conflict), 32'd0);
        @(negedge clk);
        check("rst hold wr_en", 32'(bus.wr_en), 32'd0);
        reset = 1'b0;
        #1;
        check("post gnt",      32'(bus.gnt),      32'(4'b0010));
        check("post sel",      32'(bus.sel),      32'd1);
        check("post conflict", 32'(bus.conflict), 32'd1);
        @(posedge clk);
        #1;
        check("post wr_en",   32'(bus.wr_en),   32'd1);
        check("post wr_addr", 32'(bus.wr_addr), 32'd7);
        check("post wr_data", bus.wr_data,      32'h3F800000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
